// File: rtl/wisc_mem_pkg.sv
// Shared types and defaults for the WISC-SC15 unified-memory arbiter.
// States, requester ids and the saturating-increment helper live here.
package wisc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 3;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] max);
    return (v >= max) ? max : v + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the fetch port, data port and memory port around mem_arb.
// slave = arbiter view; master = core plus memory model view.
interface mem_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_valid, if_rdata, d_valid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_valid, if_rdata, d_valid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_arb_chk.sv
// Protocol checks for mem_arb: requests must be held for the whole access,
// valids never overlap and the starvation count stays in range.
module mem_arb_chk
  import wisc_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic       clk,
  input logic       rst,
  input arb_state_e i_state,
  input req_id_e    i_win,
  input logic       i_if_req,
  input logic       i_d_req,
  input logic       i_if_valid,
  input logic       i_d_valid,
  input logic [3:0] i_starve_cnt
);
  logic w_busy;
  assign w_busy = (i_state != IDLE);

  a_if_held: assert property (@(posedge clk) disable iff (rst)
    (w_busy && i_win == REQ_IF) |-> i_if_req);
  a_d_held: assert property (@(posedge clk) disable iff (rst)
    (w_busy && i_win == REQ_D) |-> i_d_req);
  a_one_valid: assert property (@(posedge clk) disable iff (rst)
    !(i_if_valid && i_d_valid));
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    i_starve_cnt <= 4'(STARVE_MAX));
endmodule

// File: rtl/mem_arb_starve_ctr.sv
// Counts data grants that overtook a waiting fetch; saturates at MAX.
// o_sat tells the arbiter that the fetch must win the next grant.
module arb_starve_ctr
  import wisc_mem_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_clr,
  output logic [3:0] o_cnt,
  output logic       o_sat
);
  localparam logic [3:0] MAX_C = 4'(MAX);

  logic [3:0] r_cnt;

  // Clear has priority over increment; otherwise the count holds.
  always_ff @(posedge clk) begin
    if (rst)        r_cnt <= 4'd0;
    else if (i_clr) r_cnt <= 4'd0;
    else if (i_inc) r_cnt <= sat_inc(r_cnt, MAX_C);
  end

  assign o_cnt = r_cnt;
  assign o_sat = (r_cnt == MAX_C);
endmodule

// File: rtl/mem_arb.sv
// Serialises fetch and data accesses onto one multi-cycle memory port.
// Data wins unless a waiting fetch has been overtaken STARVE_MAX times.
module mem_arb
  import wisc_mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);
  arb_state_e        r_state, w_nxt;
  req_id_e           r_win, w_win;
  logic              r_we;
  logic [2:0]        r_cnt;
  logic              w_grant, w_sample, w_inc, w_clr, w_sat;
  logic [3:0]        w_starve_cnt;
  logic              r_mem_en, r_mem_we, r_if_valid, r_d_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  // Next state, grant decision and end-of-latency sampling strobe.
  always_comb begin
    w_nxt    = r_state;
    w_grant  = 1'b0;
    w_win    = REQ_D;
    w_sample = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          w_grant = 1'b1;
          w_nxt   = ISSUE;
          if (bus.if_req && (w_sat || !bus.d_req)) w_win = REQ_IF;
          else                                     w_win = REQ_D;
        end else begin
          w_nxt = IDLE;
        end
      end
      ISSUE: w_nxt = WAIT;
      WAIT: begin
        if (r_cnt == 3'd0) begin
          w_nxt    = DONE;
          w_sample = 1'b1;
        end else begin
          w_nxt = WAIT;
        end
      end
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  assign w_inc = w_grant && (w_win == REQ_D) && bus.if_req;
  assign w_clr = w_grant && (w_win == REQ_IF);

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_inc),
    .i_clr (w_clr),
    .o_cnt (w_starve_cnt),
    .o_sat (w_sat)
  );

  // Winner latch, memory strobe, latency count and registered responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win       <= REQ_IF;
      r_we        <= 1'b0;
      r_cnt       <= 3'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_mem_en   <= w_grant;
      r_mem_we   <= w_grant && (w_win == REQ_D) && bus.d_we;
      r_if_valid <= w_sample && (r_win == REQ_IF);
      r_d_valid  <= w_sample && (r_win == REQ_D);
      if (w_grant) begin
        r_win       <= w_win;
        r_we        <= (w_win == REQ_D) && bus.d_we;
        r_mem_addr  <= (w_win == REQ_D) ? bus.d_addr : bus.if_addr;
        r_mem_wdata <= (w_win == REQ_D) ? bus.d_wdata : '0;
      end
      // WAIT lasts MEM_LAT cycles: the count runs MEM_LAT-1 down to 0.
      if (r_state == ISSUE)                         r_cnt <= 3'(MEM_LAT - 1);
      else if (r_state == WAIT && r_cnt != 3'd0)    r_cnt <= r_cnt - 3'd1;
      if (w_sample && r_win == REQ_IF)              r_if_rdata <= bus.mem_rdata;
      if (w_sample && r_win == REQ_D && !r_we)      r_d_rdata  <= bus.mem_rdata;
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_valid   = r_d_valid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.stall     = bus.if_req & ~r_if_valid;

  mem_arb_chk #(.STARVE_MAX(STARVE_MAX)) u_chk (
    .clk          (clk),
    .rst          (rst),
    .i_state      (r_state),
    .i_win        (r_win),
    .i_if_req     (bus.if_req),
    .i_d_req      (bus.d_req),
    .i_if_valid   (r_if_valid),
    .i_d_valid    (r_d_valid),
    .i_starve_cnt (w_starve_cnt)
  );
endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: a timing-level transaction model checks
// every cycle, and directed scenarios pin latencies, data and grant order.
module tb_mem_arb;
  import wisc_mem_pkg::*;

  localparam int L  = 2;
  localparam int SM = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arb_if bus ();
  mem_arb_if bus1 ();
  mem_arb_if bus7 ();

  mem_arb #(.MEM_LAT(L), .STARVE_MAX(SM)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  mem_arb #(.MEM_LAT(1), .STARVE_MAX(SM)) u_d1  (.clk(clk), .rst(rst), .bus(bus1));
  mem_arb #(.MEM_LAT(7), .STARVE_MAX(SM)) u_d7  (.clk(clk), .rst(rst), .bus(bus7));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0010) return 16'hB123;
    else               return 16'h1000 + a * 16'd3;
  endfunction

  // Memory model for the main DUT: data visible exactly L cycles after mem_en.
  logic [15:0] bmem [0:1023];
  bit          bw   [0:1023];
  logic [15:0] b_addr = 16'h0;
  int          b_age  = 0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        bmem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        bw[bus.mem_addr[9:0]]   <= 1'b1;
      end
      b_addr <= bus.mem_addr;
      b_age  <= 1;
    end else if (b_age > 0 && b_age < 100) begin
      b_age <= b_age + 1;
    end
  end
  assign bus.mem_rdata = (b_age == L) ?
    (bw[b_addr[9:0]] ? bmem[b_addr[9:0]] : init_val(b_addr)) : 16'hDEAD;

  // Memory models for the latency sweep instances.
  int          a1 = 0, a7 = 0;
  logic [15:0] ad1 = 16'h0, ad7 = 16'h0;
  always @(posedge clk) begin
    if (bus1.mem_en) begin a1 <= 1; ad1 <= bus1.mem_addr; end
    else if (a1 > 0 && a1 < 100) a1 <= a1 + 1;
    if (bus7.mem_en) begin a7 <= 1; ad7 <= bus7.mem_addr; end
    else if (a7 > 0 && a7 < 100) a7 <= a7 + 1;
  end
  assign bus1.mem_rdata = (a1 == 1) ? (16'hC000 | ad1) : 16'hDEAD;
  assign bus7.mem_rdata = (a7 == 7) ? (16'hC000 | ad7) : 16'hDEAD;

  // Transaction-level model: a grant at cycle g strobes memory at g+1,
  // responds at g+2+L and frees the port for arbitration at g+3+L.
  logic [15:0] mmem [0:1023];
  bit          mw   [0:1023];
  bit          armed = 0, m_rst_prev = 0, m_pend = 0, m_win_d = 0, m_we = 0;
  int          m_tg = 0, m_free = 0, m_starve = 0;
  logic [15:0] m_addr = 16'h0, m_wdata = 16'h0, m_if_rd = 16'h0, m_d_rd = 16'h0;
  bit          e_en, e_we, e_ifv, e_dv, g_if;

  always @(negedge clk) begin
    if (armed) begin
      e_en = 0; e_we = 0; e_ifv = 0; e_dv = 0;
      if (!m_rst_prev && m_pend) begin
        if (cyc == m_tg + 1) begin e_en = 1; e_we = m_we; end
        if (cyc == m_tg + 2 + L) begin
          if (m_win_d) begin
            e_dv = 1;
            if (!m_we) m_d_rd = mw[m_addr[9:0]] ? mmem[m_addr[9:0]] : init_val(m_addr);
          end else begin
            e_ifv = 1;
            m_if_rd = mw[m_addr[9:0]] ? mmem[m_addr[9:0]] : init_val(m_addr);
          end
          m_pend = 0;
        end
      end
      chk("m_mem_en",   bus.mem_en,   e_en);
      chk("m_mem_we",   bus.mem_we,   e_we);
      chk("m_if_valid", bus.if_valid, e_ifv);
      chk("m_d_valid",  bus.d_valid,  e_dv);
      chk("m_if_rdata", bus.if_rdata, m_if_rd);
      chk("m_d_rdata",  bus.d_rdata,  m_d_rd);
      chk("m_stall",    bus.stall,    bus.if_req & ~e_ifv);
      if (e_en) chk("m_mem_addr", bus.mem_addr, m_addr);
      if (e_we) chk("m_mem_wdata", bus.mem_wdata, m_wdata);
    end
    if (rst) begin
      armed = 1; m_rst_prev = 1; m_pend = 0; m_free = cyc + 1; m_starve = 0;
      m_if_rd = 16'h0; m_d_rd = 16'h0;
    end else begin
      m_rst_prev = 0;
      if (armed && !m_pend && cyc >= m_free && (bus.if_req || bus.d_req)) begin
        g_if     = bus.if_req && (m_starve == SM || !bus.d_req);
        m_win_d  = !g_if;
        m_addr   = g_if ? bus.if_addr : bus.d_addr;
        m_we     = !g_if && bus.d_we;
        m_wdata  = bus.d_wdata;
        if (g_if)             m_starve = 0;
        else if (bus.if_req)  m_starve = (m_starve < SM) ? m_starve + 1 : SM;
        if (m_we) begin mmem[m_addr[9:0]] = m_wdata; mw[m_addr[9:0]] = 1'b1; end
        m_tg = cyc; m_free = cyc + 3 + L; m_pend = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_v(input bit dsel, output int t);
    t = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((dsel ? bus.d_valid : bus.if_valid) === 1'b1) begin t = cyc; break; end
    end
    if (t < 0) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  int   t0, tr, tv, tsw, t1, t7, ng, n_if_v, n_d_v;
  int   tb2b [3];
  bit   lv_if, lv_d, v1, v7;
  bit   gr_if [10];
  int   gr_sc [10];
  bit [7:0] exp_if = 8'b1000_1000;
  int   exp_sc [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  logic [15:0] exp_b2b [3] = '{16'h1000, 16'h1003, 16'h1006};

  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = 0; bus1.d_wdata = 0;
    bus7.if_req = 0; bus7.if_addr = 0; bus7.d_req = 0; bus7.d_we = 0; bus7.d_addr = 0; bus7.d_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Lone fetch straight out of reset.
    bus.if_addr = 16'h0010; bus.if_req = 1; t0 = cyc;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lf_cycle", cyc - t0, k);
      chk("lf_stall", bus.stall, (k < 4));
      chk("lf_mem_en", bus.mem_en, (k == 1));
      if (k == 1) begin chk("lf_addr", bus.mem_addr, 16'h0010); chk("lf_we", bus.mem_we, 1'b0); end
      if (k == 4) begin chk("lf_valid", bus.if_valid, 1'b1); chk("lf_rdata", bus.if_rdata, 16'hB123); end
    end
    tick(); bus.if_req = 0;
    @(negedge clk); chk("lf_pulse", bus.if_valid, 1'b0);

    // Store then load of the same address.
    tick(); bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0200; bus.d_wdata = 16'h5A5A;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) begin chk("st_we", bus.mem_we, 1'b1); chk("st_wdata", bus.mem_wdata, 16'h5A5A); end
      if (k == 4) begin chk("st_dvalid", bus.d_valid, 1'b1); chk("st_rdata_held", bus.d_rdata, 16'h0000); end
    end
    tick(); bus.d_we = 0; bus.d_wdata = 16'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) chk("ld_we", bus.mem_we, 1'b0);
      if (k == 4) begin chk("ld_dvalid", bus.d_valid, 1'b1); chk("ld_rdata", bus.d_rdata, 16'h5A5A); end
    end
    tick(); bus.d_req = 0;

    // Both requesters held: fetch forced through after three data grants.
    tick(); bus.if_req = 1; bus.if_addr = 16'h0300; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0100;
    ng = 0; n_if_v = 0; n_d_v = 0;
    for (int k = 0; k < 120 && (bus.if_req || bus.d_req); k++) begin
      @(negedge clk);
      if (bus.mem_en && ng < 10) begin
        gr_if[ng] = (bus.mem_addr == 16'h0300);
        gr_sc[ng] = int'(u_dut.u_starve.o_cnt);
        ng++;
      end
      lv_if = bus.if_valid; lv_d = bus.d_valid;
      tick();
      if (lv_if) begin n_if_v++; if (n_if_v == 2) bus.if_req = 0; end
      if (lv_d)  begin n_d_v++;  if (n_d_v == 7)  bus.d_req = 0; end
    end
    chk("ct_done", {bus.if_req, bus.d_req}, 2'b00);
    chk("ct_grants", ng, 9);
    for (int i = 0; i < 8; i++) begin
      chk("ct_order", gr_if[i], exp_if[i]);
      chk("ct_starve", gr_sc[i], exp_sc[i]);
    end

    // Back-to-back fetches, each re-issued the cycle after its valid.
    bus.if_req = 1; bus.if_addr = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      wait_v(1'b0, tb2b[i]);
      chk("b2b_rdata", bus.if_rdata, exp_b2b[i]);
      tick();
      if (i < 2) bus.if_addr = 16'(i + 1);
      else       bus.if_req = 0;
      @(negedge clk); chk("b2b_width", bus.if_valid, 1'b0);
    end
    chk("b2b_gap01", tb2b[1] - tb2b[0], 5);
    chk("b2b_gap12", tb2b[2] - tb2b[1], 5);

    // Reset during the WAIT of a load, then the held request reissues.
    tick(); bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0200;
    @(negedge clk);
    @(negedge clk); chk("rs_issue", bus.mem_en, 1'b1);
    tick(); rst = 1;
    @(negedge clk); chk("rs_in_wait", u_dut.r_state, WAIT);
    tick(); rst = 0; tr = cyc;
    @(negedge clk);
    chk("rs_state", u_dut.r_state, IDLE);
    chk("rs_outs", {bus.mem_en, bus.mem_we, bus.if_valid, bus.d_valid}, 4'b0000);
    chk("rs_d_rdata", bus.d_rdata, 16'h0000);
    chk("rs_if_rdata", bus.if_rdata, 16'h0000);
    chk("rs_mem_addr", bus.mem_addr, 16'h0000);
    wait_v(1'b1, tv);
    chk("rs_relat", tv - tr, 4);
    chk("rs_rdata", bus.d_rdata, 16'h5A5A);
    tick(); bus.d_req = 0;
    repeat (3) @(negedge clk);

    // Latency sweep on the MEM_LAT=1 and MEM_LAT=7 instances.
    tick(); bus1.if_addr = 16'h0042; bus1.if_req = 1; bus7.if_addr = 16'h0042; bus7.if_req = 1;
    tsw = cyc; t1 = -1; t7 = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      v1 = bus1.if_valid; v7 = bus7.if_valid;
      if (v1) begin t1 = cyc; chk("sw1_rdata", bus1.if_rdata, 16'hC042); end
      if (v7) begin t7 = cyc; chk("sw7_rdata", bus7.if_rdata, 16'hC042); end
      tick();
      if (v1) bus1.if_req = 0;
      if (v7) bus7.if_req = 0;
    end
    chk("sw1_lat", t1 - tsw, 3);
    chk("sw7_lat", t7 - tsw, 9);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
